// File: rtl/rr_grant_ctrl_if.sv
// Bundle between a set of requesters and the round-robin grant controller.
// The master side drives requests and release; the slave side returns grant state.
interface rr_grant_ctrl_if #(
    parameter int N  = 8,
    parameter int IW = 3
);
    logic [N-1:0]  req;
    logic          rel;
    logic [N-1:0]  pri;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_id;
    logic          busy;
    logic          timeout;

    modport master (
        output req,
        output rel,
        input  pri,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  rel,
        output pri,
        output gnt,
        output gnt_id,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: one-hot priority pointer, circular search,
// registered grant held until release, request drop or hold-limit revoke.
module rr_grant_ctrl #(
    parameter int N       = 8,
    parameter int IW      = 3,
    parameter int MAXHOLD = 16,
    parameter int CW      = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_grant_ctrl_if.slave     bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CW-1:0] MAXHOLD_C = CW'(MAXHOLD);
    localparam logic [N-1:0]  PRI_RST_C = {{(N-1){1'b0}}, 1'b1};

    // Binary index of a one-hot vector; OR-reduction is exact for one-hot input.
    function automatic logic [IW-1:0] onehot_to_idx(input logic [N-1:0] v);
        logic [IW-1:0] idx;
        idx = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx = idx | (v[i] ? IW'(i) : {IW{1'b0}});
        end
        return idx;
    endfunction

    // One-hot vector rotated left by one position, wrapping the top bit to bit 0.
    function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
        return {v[N-2:0], v[N-1]};
    endfunction

    state_t         state_r;
    state_t         state_nxt_s;
    logic [N-1:0]   pri_r;
    logic [N-1:0]   pri_nxt_s;
    logic [N-1:0]   gnt_r;
    logic [N-1:0]   gnt_nxt_s;
    logic [IW-1:0]  gnt_id_r;
    logic [IW-1:0]  gnt_id_nxt_s;
    logic           busy_r;
    logic           busy_nxt_s;
    logic           timeout_r;
    logic           timeout_nxt_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_nxt_s;

    logic [2*N-1:0] req_dbl_s;
    logic [2*N-1:0] win_dbl_s;
    logic [N-1:0]   win_s;
    logic           owner_req_s;

    // Circular search: subtracting the pointer from the doubled request vector
    // isolates the first set bit at or above the pointer, wrapping via the upper copy.
    always_comb begin
        req_dbl_s = {bus.req, bus.req};
        win_dbl_s = req_dbl_s & ~(req_dbl_s - {{N{1'b0}}, pri_r});
        win_s     = win_dbl_s[N-1:0] | win_dbl_s[2*N-1:N];
    end

    assign owner_req_s = bus.req[gnt_id_r];

    // Next-state and next-output logic for the IDLE/HOLD controller.
    always_comb begin
        state_nxt_s   = state_r;
        pri_nxt_s     = pri_r;
        gnt_nxt_s     = gnt_r;
        gnt_id_nxt_s  = gnt_id_r;
        busy_nxt_s    = busy_r;
        cnt_nxt_s     = cnt_r;
        timeout_nxt_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_nxt_s  = ST_HOLD;
                    gnt_nxt_s    = win_s;
                    gnt_id_nxt_s = onehot_to_idx(win_s);
                    busy_nxt_s   = 1'b1;
                    cnt_nxt_s    = {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    state_nxt_s  = ST_IDLE;
                    gnt_nxt_s    = {N{1'b0}};
                    busy_nxt_s   = 1'b0;
                    cnt_nxt_s    = {CW{1'b0}};
                end
            end
            ST_HOLD: begin
                // A normal end outranks the hold limit, so a coincident rel suppresses timeout.
                if (bus.rel || !owner_req_s) begin
                    state_nxt_s   = ST_IDLE;
                    gnt_nxt_s     = {N{1'b0}};
                    busy_nxt_s    = 1'b0;
                    cnt_nxt_s     = {CW{1'b0}};
                    pri_nxt_s     = rotl1(gnt_r);
                end else if (cnt_r == MAXHOLD_C) begin
                    state_nxt_s   = ST_IDLE;
                    gnt_nxt_s     = {N{1'b0}};
                    busy_nxt_s    = 1'b0;
                    cnt_nxt_s     = {CW{1'b0}};
                    pri_nxt_s     = rotl1(gnt_r);
                    timeout_nxt_s = 1'b1;
                end else if (cnt_r < MAXHOLD_C) begin
                    cnt_nxt_s     = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    cnt_nxt_s     = MAXHOLD_C;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                pri_nxt_s    = PRI_RST_C;
                gnt_nxt_s    = {N{1'b0}};
                gnt_id_nxt_s = {IW{1'b0}};
                busy_nxt_s   = 1'b0;
                cnt_nxt_s    = {CW{1'b0}};
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            pri_r     <= PRI_RST_C;
            gnt_r     <= {N{1'b0}};
            gnt_id_r  <= {IW{1'b0}};
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
            cnt_r     <= {CW{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            pri_r     <= pri_nxt_s;
            gnt_r     <= gnt_nxt_s;
            gnt_id_r  <= gnt_id_nxt_s;
            busy_r    <= busy_nxt_s;
            timeout_r <= timeout_nxt_s;
            cnt_r     <= cnt_nxt_s;
        end
    end

    assign bus.pri     = pri_r;
    assign bus.gnt     = gnt_r;
    assign bus.gnt_id  = gnt_id_r;
    assign bus.busy    = busy_r;
    assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl: grant order, wrap, fairness, timeout,
// release/timeout collision, request drop and asynchronous reset.
module tb_rr_grant_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rr_grant_ctrl_if #(.N(8), .IW(3)) bus ();

    rr_grant_ctrl #(.N(8), .IW(3), .MAXHOLD(16), .CW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant, busy (derived from expected grant) and timeout in one call.
    task automatic chk_gnt(input string tag, input logic [7:0] eg, input logic et);
        check_val({tag, ".gnt"}, 32'(bus.gnt), 32'(eg));
        check_val({tag, ".busy"}, 32'(bus.busy), 32'(|eg));
        check_val({tag, ".timeout"}, 32'(bus.timeout), 32'(et));
    endtask

    task automatic chk_id(input string tag, input logic [2:0] ei);
        check_val({tag, ".gnt_id"}, 32'(bus.gnt_id), 32'(ei));
    endtask

    task automatic chk_pri(input string tag, input logic [7:0] ep);
        check_val({tag, ".pri"}, 32'(bus.pri), 32'(ep));
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = 8'h00;
        bus.rel = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=expired exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_g;
        total = 0;
        bad   = 0;

        // 1: basic grant, release, rotation
        do_reset();
        chk_gnt("rst", 8'h00, 1'b0);
        chk_pri("rst", 8'h01);
        chk_id("rst", 3'd0);
        bus.rel = 1'b1;               // rel in IDLE is ignored
        tick();
        chk_gnt("rel_idle", 8'h00, 1'b0);
        bus.rel = 1'b0;
        bus.req = 8'h05;
        tick();
        chk_gnt("t1_g0", 8'h01, 1'b0);
        chk_id("t1_g0", 3'd0);
        bus.rel = 1'b1;
        tick();
        chk_gnt("t1_end", 8'h00, 1'b0);
        chk_pri("t1_end", 8'h02);
        bus.rel = 1'b0;
        tick();
        chk_gnt("t1_g2", 8'h04, 1'b0);
        chk_id("t1_g2", 3'd2);
        chk_pri("t1_g2", 8'h02);
        bus.req = 8'h00;
        tick();
        chk_gnt("t1_drop", 8'h00, 1'b0);
        chk_pri("t1_drop", 8'h08);

        // 2: wrap-around search
        bus.req = 8'h40;
        tick();
        chk_gnt("t2_g6", 8'h40, 1'b0);
        bus.rel = 1'b1;
        tick();
        chk_pri("t2_p7", 8'h80);
        bus.rel = 1'b0;
        bus.req = 8'h02;
        tick();
        chk_gnt("t2_wrap", 8'h02, 1'b0);
        chk_id("t2_wrap", 3'd1);
        bus.rel = 1'b1;
        tick();
        chk_gnt("t2_end", 8'h00, 1'b0);
        chk_pri("t2_end", 8'h04);
        bus.rel = 1'b0;
        bus.req = 8'h00;
        tick();

        // 3: fairness with all requesting
        do_reset();
        bus.req = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
            exp_g = 8'h01 << (k % 8);
            chk_gnt($sformatf("t3_g%0d", k), exp_g, 1'b0);
            chk_id($sformatf("t3_g%0d", k), 3'(k % 8));
            bus.rel = 1'b1;
            tick();
            chk_gnt($sformatf("t3_dead%0d", k), 8'h00, 1'b0);
            bus.rel = 1'b0;
            tick();
        end
        chk_gnt("t3_next", 8'h02, 1'b0);
        bus.req = 8'h00;
        tick();
        chk_pri("t3_end", 8'h04);
        tick();

        // 4: hold limit forces revoke
        bus.req = 8'h10;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk_gnt($sformatf("t4_hold%0d", i), 8'h10, 1'b0);
            tick();
        end
        chk_gnt("t4_to", 8'h00, 1'b1);
        chk_pri("t4_to", 8'h20);
        tick();
        chk_gnt("t4_regnt", 8'h10, 1'b0);
        chk_id("t4_regnt", 3'd4);

        // 5a: rel coinciding with the hold limit is a normal end
        for (int i = 0; i < 15; i++) tick();
        chk_gnt("t5_last", 8'h10, 1'b0);
        bus.rel = 1'b1;
        tick();
        chk_gnt("t5_rel", 8'h00, 1'b0);
        chk_pri("t5_rel", 8'h20);
        bus.rel = 1'b0;
        tick();
        chk_gnt("t5_regnt", 8'h10, 1'b0);

        // 5b: non-owner request ignored, then owner drops
        bus.req = 8'h11;
        tick();
        tick();
        chk_gnt("t5_other", 8'h10, 1'b0);
        bus.req = 8'h01;
        tick();
        chk_gnt("t5_drop", 8'h00, 1'b0);
        chk_pri("t5_drop", 8'h20);
        tick();
        chk_gnt("t5_g0", 8'h01, 1'b0);
        bus.rel = 1'b1;
        tick();
        chk_pri("t5_g0end", 8'h02);
        bus.rel = 1'b0;
        bus.req = 8'h00;
        tick();

        // 6: asynchronous reset mid-hold
        bus.req = 8'h08;
        tick();
        chk_gnt("t6_g3", 8'h08, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_gnt("t6_arst", 8'h00, 1'b0);
        chk_pri("t6_arst", 8'h01);
        chk_id("t6_arst", 3'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_gnt("t6_after", 8'h08, 1'b0);
        chk_id("t6_after", 3'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
